gate_sweep_checker: RTL and testbench
=====================================

# gate_sweep_checker

Parametrised, synthesizable exhaustive truth-table checker for an N-input, 1-output combinational gate block. On START it drives every input combination 0 … 2^N_IN−1 onto the device under test and samples the DUT response after a programmable dwell. It compares each response against a selected reference function and reports a mismatch count, the first failing vector and pass/fail. It sits beside the gate blocks under test and replaces hand-written fixed-vector stimulus with on-chip, any-width self-checking.

## Interface
- N_IN, 2, number of DUT inputs; legal values 1–8.
- DWELL, 1, extra settle cycles per vector before the response is sampled; legal values 0–15.

- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset. One clock; reset asserts asynchronously and is active-low.
- START  in  1  sweep request, sampled in IDLE only.
- OP  in  3  reference function, latched at START:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; each is a reduction over all N_IN bits.
  - 6 constant 0, 7 constant 1.
- STIM  out  N_IN  vector driven to the DUT inputs.
- RESP  in  1  DUT output.
- BUSY  out  1  high while a sweep is in progress.
- DONE  out  1  single-cycle pulse at the end of a sweep.
- PASS  out  1  ERR_CNT==0 at the end of the sweep; held until the next START.
- ERR_CNT  out  N_IN+1  mismatch count, saturating at 2^N_IN.
- FIRST_FAIL  out  N_IN  STIM value of the first mismatch; meaningful only when ERR_CNT≠0.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE:
  - On START=1: latch OP, clear ERR_CNT, PASS and FIRST_FAIL, set STIM=0 and the dwell counter to 0, assert BUSY, then go to RUN.
- RUN:
  - Each vector is held for exactly DWELL+1 cycles.
  - The dwell counter counts 0 … DWELL.
  - On the edge where the dwell counter equals DWELL, RESP is compared with expected(OP_latched, STIM).
  - On a mismatch, ERR_CNT increments. If ERR_CNT was 0 before that edge, FIRST_FAIL is loaded with STIM.
  - If STIM is all-ones on that same edge, go to FINISH. Otherwise STIM increments and the dwell counter returns to 0.
- FINISH:
  - One cycle with DONE=1 and BUSY=0.
  - PASS is set to (ERR_CNT==0), including any mismatch from the final vector.
  - Return to IDLE.
- STIM holds its last value in IDLE and FINISH.
- Expected-value arithmetic uses the latched OP. A change on OP during RUN has no effect.
- START during RUN or FINISH is ignored and is not queued.
- RST_N low at any time, including mid-sweep, forces IDLE immediately with outputs at their reset values. No DONE pulse is generated for the aborted sweep.

## Timing
- Reset values: STIM=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_FAIL=0.
- START sampled at edge e0:
  - BUSY=1 and STIM=0 are visible after e0.
  - Vector k is driven from edge e0+k·(DWELL+1).
  - RESP for vector k is sampled at edge e0+(k+1)·(DWELL+1).
- DONE is high during the cycle after edge e0+2^N_IN·(DWELL+1).
  - Total START-to-DONE latency is 2^N_IN·(DWELL+1) cycles.
  - For the defaults this is 8 cycles.
- The DUT must settle within DWELL+1 cycles of a STIM change. RESP is sampled with no resynchronisation.
- A START asserted in the DONE cycle is ignored. The earliest restart is the following cycle.

## Configuration
- STOP_ON_FAIL_EN:
  - Defined: the first mismatch ends the sweep. The machine goes to FINISH on that same sampling edge. Final state is ERR_CNT=1, FIRST_FAIL = the failing vector, PASS=0, and DONE follows one cycle later.
  - Undefined: every vector is always swept and all mismatches are counted.

## Test plan
- Default parameters, OP=0, DUT is a correct AND:
  - STIM sequence is 0,0,1,1,2,2,3,3.
  - DONE pulses 8 cycles after START.
  - PASS=1, ERR_CNT=0.
- N_IN=2, OP=2 (XOR), DUT is OR:
  - Only vector 3 mismatches.
  - ERR_CNT=1, FIRST_FAIL=3, PASS=0.
- N_IN=4, DWELL=0, OP=3 (NAND), DUT is stuck at 0:
  - 15 mismatches, ERR_CNT=15, FIRST_FAIL=0.
  - DONE 16 cycles after START.
- OP=7, DUT is stuck at 0, N_IN=3:
  - ERR_CNT=8 (the maximum), FIRST_FAIL=0.
  - With STOP_ON_FAIL_EN defined: ERR_CNT=1 and DONE 2 cycles after START (DWELL=1).
- START pulsed again mid-sweep and OP toggled mid-sweep:
  - No restart and no change to results relative to the clean run.
- RST_N pulsed low mid-sweep (at vector 2):
  - All outputs return to 0 asynchronously and no DONE is seen.
  - A new START then completes a full, correct sweep.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker
//
// Exhaustive truth-table checker for an N_IN-input, 1-output combinational
// gate block. On START every input vector 0 .. 2^N_IN-1 is driven onto STIM
// and held for DWELL+1 cycles. RESP is compared against a reference function
// on the last cycle of each vector. The block reports the mismatch count, the
// first failing vector and pass/fail.
//
// Parameters
//   N_IN   number of DUT inputs (1..8)
//   DWELL  extra settle cycles per vector before sampling (0..15)
//
// Ports
//   CLK         in   rising-edge clock
//   RST_N       in   asynchronous active-low reset
//   START       in   sweep request, honoured in IDLE only
//   OP          in   reference function, latched at START
//                    0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR,
//                    6 const 0, 7 const 1
//   STIM        out  vector driven to the DUT inputs
//   RESP        in   DUT output (sampled without resynchronisation)
//   BUSY        out  high while a sweep is in progress
//   DONE        out  one-cycle pulse at the end of a sweep
//   PASS        out  no mismatches in the last sweep; held until next START
//   ERR_CNT     out  mismatch count, saturating at 2^N_IN
//   FIRST_FAIL  out  STIM value of the first mismatch (valid if ERR_CNT!=0)
//
// Build option
//   STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep.
// ---------------------------------------------------------------------------
module gate_sweep_checker #(
  parameter int N_IN  = 2,
  parameter int DWELL = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic [2:0]      OP,
  output logic [N_IN-1:0] STIM,
  input  logic            RESP,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [N_IN:0]   ERR_CNT,
  output logic [N_IN-1:0] FIRST_FAIL
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  localparam logic [N_IN:0]   ERR_MAX    = {1'b1, {N_IN{1'b0}}};
  localparam logic [N_IN:0]   ERR_ONE    = {{N_IN{1'b0}}, 1'b1};
  localparam logic [N_IN-1:0] STIM_ONE   = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [3:0]      DWELL_LAST = 4'(DWELL);

  state_t        state;
  logic [2:0]    op_l;
  logic [3:0]    dwell_cnt;

  logic          sample;
  logic          mismatch;
  logic          finish_now;
  logic [N_IN:0] err_next;

  function automatic logic ref_bit(input logic [2:0] op, input logic [N_IN-1:0] v);
    logic r;
    case (op)
      3'd0:    r = &v;
      3'd1:    r = |v;
      3'd2:    r = ^v;
      3'd3:    r = ~&v;
      3'd4:    r = ~|v;
      3'd5:    r = ~^v;
      3'd6:    r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Sampling happens on the last dwell cycle of each vector; the count
  // saturates so a full-mismatch sweep reads exactly 2^N_IN.
  always_comb begin
    sample   = (state == RUN) && (dwell_cnt == DWELL_LAST);
    mismatch = sample && (RESP != ref_bit(op_l, STIM));
    err_next = ERR_CNT;
    if (mismatch && (ERR_CNT != ERR_MAX)) begin
      err_next = ERR_CNT + ERR_ONE;
    end
`ifdef STOP_ON_FAIL_EN
    finish_now = sample && ((&STIM) || mismatch);
`else
    finish_now = sample && (&STIM);
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      op_l       <= 3'd0;
      dwell_cnt  <= 4'd0;
      STIM       <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      ERR_CNT    <= '0;
      FIRST_FAIL <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            op_l       <= OP;
            ERR_CNT    <= '0;
            PASS       <= 1'b0;
            FIRST_FAIL <= '0;
            STIM       <= '0;
            dwell_cnt  <= 4'd0;
            BUSY       <= 1'b1;
            state      <= RUN;
          end
        end

        RUN: begin
          if (sample) begin
            ERR_CNT <= err_next;
            if (mismatch && (ERR_CNT == '0)) begin
              FIRST_FAIL <= STIM;
            end
            if (finish_now) begin
              // PASS uses the post-update count so the final vector counts.
              state <= FINISH;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              PASS  <= (err_next == '0);
            end else begin
              STIM      <= STIM + STIM_ONE;
              dwell_cnt <= 4'd0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 4'd1;
          end
        end

        // DONE is high for this one cycle; START here is deliberately ignored.
        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start = 3'b000;
  logic [2:0] op [3];
  int         mode [3];
  logic [2:0] resp;

  // Instance 0: N_IN=2 DWELL=1, 1: N_IN=4 DWELL=0, 2: N_IN=3 DWELL=1
  logic [1:0] stim_a, ff_a;
  logic [2:0] err_a;
  logic [3:0] stim_b, ff_b;
  logic [4:0] err_b;
  logic [2:0] stim_c, ff_c;
  logic [3:0] err_c;
  logic [2:0] busy, done, pass;

  logic [7:0] stim_w [3];
  logic [7:0] ff_w   [3];
  logic [8:0] err_w  [3];

  int passed = 0;
  int total  = 0;

  int         lat;
  logic       busy_start, busy_fin, done_after;
  logic [7:0] stim_log [16];
  logic       dseen;

  always #5 clk = ~clk;

  assign stim_w[0] = {6'd0, stim_a};
  assign stim_w[1] = {4'd0, stim_b};
  assign stim_w[2] = {5'd0, stim_c};
  assign ff_w[0]   = {6'd0, ff_a};
  assign ff_w[1]   = {4'd0, ff_b};
  assign ff_w[2]   = {5'd0, ff_c};
  assign err_w[0]  = {6'd0, err_a};
  assign err_w[1]  = {4'd0, err_b};
  assign err_w[2]  = {5'd0, err_c};

  gate_sweep_checker #(.N_IN(2), .DWELL(1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start[0]), .OP(op[0]), .STIM(stim_a),
    .RESP(resp[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
    .ERR_CNT(err_a), .FIRST_FAIL(ff_a));

  gate_sweep_checker #(.N_IN(4), .DWELL(0)) dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start[1]), .OP(op[1]), .STIM(stim_b),
    .RESP(resp[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
    .ERR_CNT(err_b), .FIRST_FAIL(ff_b));

  gate_sweep_checker #(.N_IN(3), .DWELL(1)) dut_c (
    .CLK(clk), .RST_N(rst_n), .START(start[2]), .OP(op[2]), .STIM(stim_c),
    .RESP(resp[2]), .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]),
    .ERR_CNT(err_c), .FIRST_FAIL(ff_c));

  // Gate under test: 0 correct AND, 1 correct OR, anything else stuck at 0.
  function automatic logic gate_model(input int m, input logic [7:0] s, input int n);
    logic [7:0] mask;
    mask = (8'd1 << n) - 8'd1;
    case (m)
      0:       return &(s | ~mask);
      1:       return |(s & mask);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    resp    = 3'b000;
    resp[0] = gate_model(mode[0], stim_w[0], 2);
    resp[1] = gate_model(mode[1], stim_w[1], 4);
    resp[2] = gate_model(mode[2], stim_w[2], 3);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one sweep on instance i. OP is scrambled right after START to show
  // it is latched; with disturb set, START is re-pulsed and OP changed again
  // mid-sweep. lat is the START-to-DONE latency in cycles.
  task automatic sweep(input int i, input logic [2:0] o, input int m, input bit disturb);
    int k;
    op[i]    = o;
    mode[i]  = m;
    start[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[i]   = 1'b0;
    op[i]      = ~o;
    busy_start = busy[i];
    k = 0;
    while (!done[i] && k < 200) begin
      if (k < 16) stim_log[k] = stim_w[i];
      if (disturb && k == 2) begin
        start[i] = 1'b1;
        op[i]    = o ^ 3'd1;
      end else begin
        start[i] = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start[i]   = 1'b0;
    lat        = k;
    busy_fin   = busy[i];
    @(negedge clk);
    done_after = done[i];
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      op[i]   = 3'd0;
      mode[i] = 0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_stim", stim_w[0], 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err",  err_w[0], 0);
    check("rst_ff",   ff_w[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // N_IN=2 DWELL=1, OP=AND, correct AND gate
    sweep(0, 3'd0, 0, 1'b0);
    check("and_busy_start", busy_start, 1);
    for (int k = 0; k < 8; k++) check($sformatf("and_stim%0d", k), stim_log[k], k / 2);
    check("and_lat", lat, 8);
    check("and_busy_fin", busy_fin, 0);
    check("and_done_pulse", done_after, 0);
    check("and_pass", pass[0], 1);
    check("and_err", err_w[0], 0);
    repeat (3) @(negedge clk);
    check("and_pass_held", pass[0], 1);

    // OP=XOR, DUT is OR: only vector 3 disagrees
    sweep(0, 3'd2, 1, 1'b0);
    check("xor_lat", lat, 8);
    check("xor_err", err_w[0], 1);
    check("xor_ff",  ff_w[0], 3);
    check("xor_pass", pass[0], 0);

    // Same run with START re-pulsed and OP toggled mid-sweep
    sweep(0, 3'd2, 1, 1'b1);
    check("dist_lat", lat, 8);
    check("dist_err", err_w[0], 1);
    check("dist_ff",  ff_w[0], 3);
    check("dist_pass", pass[0], 0);

    // N_IN=4 DWELL=0, OP=NAND, DUT stuck at 0
    sweep(1, 3'd3, 2, 1'b0);
`ifdef STOP_ON_FAIL_EN
    check("nand_lat", lat, 1);
    check("nand_err", err_w[1], 1);
`else
    check("nand_lat", lat, 16);
    check("nand_err", err_w[1], 15);
`endif
    check("nand_ff", ff_w[1], 0);
    check("nand_pass", pass[1], 0);

    // N_IN=3 DWELL=1, OP=const 1, DUT stuck at 0: every vector fails
    sweep(2, 3'd7, 2, 1'b0);
`ifdef STOP_ON_FAIL_EN
    check("c1_lat", lat, 2);
    check("c1_err", err_w[2], 1);
`else
    check("c1_lat", lat, 16);
    check("c1_err", err_w[2], 8);
`endif
    check("c1_ff", ff_w[2], 0);
    check("c1_pass", pass[2], 0);

    // Reset mid-sweep at vector 2
    op[0]    = 3'd0;
    mode[0]  = 0;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_stim_before", stim_w[0], 2);
    check("abort_busy_before", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_stim", stim_w[0], 0);
    check("abort_busy", busy[0], 0);
    check("abort_err",  err_w[0], 0);
    dseen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done[0]) dseen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done[0]) dseen = 1'b1;
    end
    check("abort_no_done", dseen, 0);
    check("abort_idle_busy", busy[0], 0);

    sweep(0, 3'd0, 0, 1'b0);
    check("rerun_lat", lat, 8);
    check("rerun_pass", pass[0], 1);
    check("rerun_err", err_w[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
